// File: rtl/multi_ch_freq_serial_out_pkg.sv
// Shared constants, channel state encoding and sizing helper
// for the multi-channel variable-period serial output.
package multi_ch_freq_serial_out_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;

    localparam int DEF_CH_NUM    = 4;
    localparam int DEF_SEL_W     = 2;
    localparam int DEF_DATA_BIT  = 32;
    localparam int DEF_TICK_FAST = 31;
    localparam int DEF_TICK_SLOW = 63;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_ch_freq_serial_out_ch.sv
// One serial channel: bit/tick counters, one-deep command shadow,
// deferred stop request and pattern-end chaining.
module multi_ch_freq_serial_out_ch
    import multi_ch_freq_serial_out_pkg::*;
#(
    parameter int DATA_BIT  = DEF_DATA_BIT,
    parameter int TICK_FAST = DEF_TICK_FAST,
    parameter int TICK_SLOW = DEF_TICK_SLOW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                mode_i,
    input  logic [DATA_BIT-1:0] pat_i,
    input  logic [DATA_BIT-1:0] frq_i,
    output logic                serial_o,
    output logic                bit_tick_o,
    output logic                done_tick_o,
    output logic                busy_o,
    output logic                ovf_o
);

    localparam int IW = cw(DATA_BIT);
    localparam int TW = cw(TICK_SLOW + 1);
    localparam logic [TW-1:0] PER_F = TW'(TICK_FAST);
    localparam logic [TW-1:0] PER_S = TW'(TICK_SLOW);
    localparam logic [IW-1:0] LAST  = IW'(DATA_BIT - 1);

    ch_state_e           state_q, state_d;
    logic [DATA_BIT-1:0] pat_q, pat_d;
    logic [DATA_BIT-1:0] frq_q, frq_d;
    logic [DATA_BIT-1:0] sh_pat_q, sh_pat_d;
    logic [DATA_BIT-1:0] sh_frq_q, sh_frq_d;
    logic                mode_q, mode_d;
    logic                sh_mode_q, sh_mode_d;
    logic                sh_vld_q, sh_vld_d;
    logic                stop_req_q, stop_req_d;
    logic                out_q, out_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [IW-1:0]       idx_q, idx_d;

    logic [IW-1:0] nidx;
    logic [TW-1:0] per;
    logic          run;
    logic          bit_end;
    logic          last;
    logic          ld_start;
    logic          ld_stop;
    logic          to_idle;

    always_comb begin
        run      = (state_q == CH_RUN);
        per      = frq_q[idx_q] ? PER_F : PER_S;
        bit_end  = run && (tick_q == per);
        last     = (idx_q == LAST);
        nidx     = idx_q + 1'b1;
        ld_start = ld_i && start_i && !stop_i;
        ld_stop  = ld_i && stop_i;
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        frq_d      = frq_q;
        mode_d     = mode_q;
        sh_pat_d   = sh_pat_q;
        sh_frq_d   = sh_frq_q;
        sh_mode_d  = sh_mode_q;
        sh_vld_d   = sh_vld_q;
        stop_req_d = stop_req_q;
        out_d      = out_q;
        tick_d     = tick_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        ovf_d      = 1'b0;
        to_idle    = 1'b0;

        unique case (state_q)
            CH_IDLE: begin
                if (ld_start) begin
                    state_d = CH_RUN;
                    pat_d   = pat_i;
                    frq_d   = frq_i;
                    mode_d  = mode_i;
                    tick_d  = '0;
                    idx_d   = '0;
                    out_d   = pat_i[0];
                end
            end
            CH_RUN: begin
                if (ld_stop) begin
                    sh_vld_d   = 1'b0;
                    stop_req_d = 1'b1;
                end
                // A start landing exactly on pattern end skips the shadow.
                if (ld_start && !(bit_end && last)) begin
                    ovf_d     = sh_vld_q;
                    sh_pat_d  = pat_i;
                    sh_frq_d  = frq_i;
                    sh_mode_d = mode_i;
                    sh_vld_d  = 1'b1;
                end
                tick_d = tick_q + 1'b1;
                if (bit_end) begin
                    tick_d = '0;
                    if (stop_req_q || ld_stop) begin
                        to_idle = 1'b1;
                    end else if (!last) begin
                        idx_d = nidx;
                        out_d = pat_q[nidx];
                    end else if (ld_start) begin
                        pat_d    = pat_i;
                        frq_d    = frq_i;
                        mode_d   = mode_i;
                        ovf_d    = sh_vld_q;
                        sh_vld_d = 1'b0;
                        idx_d    = '0;
                        out_d    = pat_i[0];
                    end else if (sh_vld_q) begin
                        pat_d    = sh_pat_q;
                        frq_d    = sh_frq_q;
                        mode_d   = sh_mode_q;
                        sh_vld_d = 1'b0;
                        idx_d    = '0;
                        out_d    = sh_pat_q[0];
                    end else if (mode_q == MODE_REPEAT) begin
                        idx_d = '0;
                        out_d = pat_q[0];
                    end else begin
                        to_idle = 1'b1;
                    end
                end
            end
        endcase

        if (to_idle) begin
            state_d    = CH_IDLE;
            out_d      = 1'b0;
            done_d     = 1'b1;
            stop_req_d = 1'b0;
            sh_vld_d   = 1'b0;
            idx_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CH_IDLE;
            pat_q      <= '0;
            frq_q      <= '0;
            mode_q     <= MODE_ONESHOT;
            sh_pat_q   <= '0;
            sh_frq_q   <= '0;
            sh_mode_q  <= MODE_ONESHOT;
            sh_vld_q   <= 1'b0;
            stop_req_q <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= '0;
            idx_q      <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            frq_q      <= frq_d;
            mode_q     <= mode_d;
            sh_pat_q   <= sh_pat_d;
            sh_frq_q   <= sh_frq_d;
            sh_mode_q  <= sh_mode_d;
            sh_vld_q   <= sh_vld_d;
            stop_req_q <= stop_req_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign serial_o    = out_q;
    assign bit_tick_o  = bit_end;
    assign done_tick_o = done_q;
    assign busy_o      = run;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/multi_ch_freq_serial_out.sv
// Command register, channel select decode and error/overflow pulses
// in front of CH_NUM independent serial channels.
module multi_ch_freq_serial_out
    import multi_ch_freq_serial_out_pkg::*;
#(
    parameter int CH_NUM    = DEF_CH_NUM,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int DATA_BIT  = DEF_DATA_BIT,
    parameter int TICK_FAST = DEF_TICK_FAST,
    parameter int TICK_SLOW = DEF_TICK_SLOW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    input  logic [SEL_W-1:0]    i_sel,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    output logic [CH_NUM-1:0]   o_serial_out,
    output logic [CH_NUM-1:0]   o_bit_tick,
    output logic [CH_NUM-1:0]   o_done_tick,
    output logic [CH_NUM-1:0]   o_busy,
    output logic                o_cmd_err,
    output logic                o_cmd_ovf
);

    logic                c_vld_q;
    logic [SEL_W-1:0]    c_sel_q;
    logic [DATA_BIT-1:0] c_pat_q;
    logic [DATA_BIT-1:0] c_frq_q;
    logic                c_start_q;
    logic                c_stop_q;
    logic                c_mode_q;

    logic [CH_NUM-1:0]   ld_q, ld_d;
    logic                err_q, err_d;
    logic [DATA_BIT-1:0] d_pat_q;
    logic [DATA_BIT-1:0] d_frq_q;
    logic                d_start_q;
    logic                d_stop_q;
    logic                d_mode_q;

    logic [CH_NUM-1:0]   ch_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_vld_q   <= 1'b0;
            c_sel_q   <= '0;
            c_pat_q   <= '0;
            c_frq_q   <= '0;
            c_start_q <= 1'b0;
            c_stop_q  <= 1'b0;
            c_mode_q  <= 1'b0;
        end else begin
            c_vld_q <= i_cmd_valid;
            if (i_cmd_valid) begin
                c_sel_q   <= i_sel;
                c_pat_q   <= i_output_pattern;
                c_frq_q   <= i_freq_pattern;
                c_start_q <= i_start;
                c_stop_q  <= i_stop;
                c_mode_q  <= i_mode;
            end
        end
    end

    always_comb begin
        ld_d  = '0;
        err_d = 1'b0;
        if (c_vld_q) begin
            err_d = (int'(c_sel_q) >= CH_NUM);
            for (int i = 0; i < CH_NUM; i++)
                ld_d[i] = (int'(c_sel_q) == i);
        end
    end

    // Payload travels with the strobe so back-to-back commands stay intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q      <= '0;
            err_q     <= 1'b0;
            d_pat_q   <= '0;
            d_frq_q   <= '0;
            d_start_q <= 1'b0;
            d_stop_q  <= 1'b0;
            d_mode_q  <= 1'b0;
        end else begin
            ld_q      <= ld_d;
            err_q     <= err_d;
            d_pat_q   <= c_pat_q;
            d_frq_q   <= c_frq_q;
            d_start_q <= c_start_q;
            d_stop_q  <= c_stop_q;
            d_mode_q  <= c_mode_q;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        multi_ch_freq_serial_out_ch #(
            .DATA_BIT  (DATA_BIT),
            .TICK_FAST (TICK_FAST),
            .TICK_SLOW (TICK_SLOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .ld_i        (ld_q[g]),
            .start_i     (d_start_q),
            .stop_i      (d_stop_q),
            .mode_i      (d_mode_q),
            .pat_i       (d_pat_q),
            .frq_i       (d_frq_q),
            .serial_o    (o_serial_out[g]),
            .bit_tick_o  (o_bit_tick[g]),
            .done_tick_o (o_done_tick[g]),
            .busy_o      (o_busy[g]),
            .ovf_o       (ch_ovf[g])
        );
    end

    assign o_cmd_err = err_q;
    assign o_cmd_ovf = |ch_ovf;

endmodule
